// File: rtl/ascon_bdi_pad_pkg.sv
// Shared Ascon definitions: segment type codes, word width, pad byte and
// the FSM state type used by the BDI padding stage.
package ascon_bdi_pad_pkg;

  localparam int         CCW      = 32;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [3:0] D_AD    = 4'h1;
  localparam logic [3:0] D_PTCT  = 4'h4;
  localparam logic [3:0] D_TAG   = 4'h8;
  localparam logic [3:0] D_NONCE = 4'hC;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    PAD  = 1'b1
  } fsm_t;

endpackage

// File: rtl/ascon_bdi_pad.sv
// BDI padding stage between the host word stream and the Ascon core.
// AD and plaintext/ciphertext segments receive 10* padding on their last
// word; a full last word is followed by an extra 0x80000000 pad word.
// Optional macro ASCON_BDI_CHECK_EN enables the sticky protocol-error flag.
module ascon_bdi_pad #(
  parameter int CCW = ascon_bdi_pad_pkg::CCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CCW-1:0] s_data,
  input  logic [2:0]     s_bytes,
  input  logic [3:0]     s_type,
  input  logic           s_last,
  input  logic           s_eoi,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [CCW-1:0] bdi,
  output logic [3:0]     bdi_type,
  output logic           bdi_eot,
  output logic           bdi_eoi,
  output logic           bdi_valid,
  input  logic           bdi_ready,
  output logic           err
);

  import ascon_bdi_pad_pkg::*;

  // Keep the first n bytes, place the pad byte at byte n, zero the rest.
  function automatic logic [CCW-1:0] pad_partial(input logic [CCW-1:0] data,
                                                 input logic [2:0]     n);
    logic [CCW-1:0] w;
    case (n)
      3'd0:    w = {PAD_BYTE, 24'h000000};
      3'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
      3'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
      3'd3:    w = {data[31:8], PAD_BYTE};
      default: w = data;
    endcase
    return w;
  endfunction

  fsm_t           fsm;
  logic [3:0]     pad_type;
  logic           pad_eoi;
  logic           slot_free;
  logic           accept;
  logic           padded;
  logic           full_last;
  logic [2:0]     eff_bytes;
  logic [CCW-1:0] next_data;
  logic           next_eot;
  logic           next_eoi;

  assign slot_free = !bdi_valid || bdi_ready;
  assign s_ready   = slot_free && (fsm == PASS) && !rst;
  assign accept    = s_valid && s_ready;
  assign padded    = (s_type == D_AD) || (s_type == D_PTCT);
  // Out-of-range byte counts are forwarded as a full word.
  assign eff_bytes = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
  assign full_last = padded && s_last && (eff_bytes == 3'd4);

  // Build the word to load into the output slot from the current host word.
  always_comb begin
    next_data = s_data;
    next_eot  = s_last;
    next_eoi  = s_eoi;
    if (padded) begin
      if (s_last && (eff_bytes != 3'd4)) begin
        next_data = pad_partial(s_data, eff_bytes);
        next_eot  = 1'b1;
        next_eoi  = s_eoi;
      end else begin
        // Mid-segment word, or full last word whose pad word follows.
        next_data = s_data;
        next_eot  = 1'b0;
        next_eoi  = 1'b0;
      end
    end else begin
      next_data = s_data;
      next_eot  = s_last;
      next_eoi  = s_eoi;
    end
  end

  // Output slot and PASS/PAD state: accept host words, inject the pad word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= PASS;
      bdi       <= '0;
      bdi_type  <= 4'h0;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
      bdi_valid <= 1'b0;
      pad_type  <= 4'h0;
      pad_eoi   <= 1'b0;
    end else begin
      case (fsm)
        PASS: begin
          if (accept) begin
            bdi       <= next_data;
            bdi_type  <= s_type;
            bdi_eot   <= next_eot;
            bdi_eoi   <= next_eoi;
            bdi_valid <= 1'b1;
            if (full_last) begin
              fsm      <= PAD;
              pad_type <= s_type;
              pad_eoi  <= s_eoi;
            end
          end else if (bdi_ready) begin
            bdi_valid <= 1'b0;
          end
        end
        PAD: begin
          if (slot_free) begin
            bdi       <= {PAD_BYTE, 24'h000000};
            bdi_type  <= pad_type;
            bdi_eot   <= 1'b1;
            bdi_eoi   <= pad_eoi;
            bdi_valid <= 1'b1;
            fsm       <= PASS;
          end
        end
        default: begin
          fsm       <= PASS;
          bdi_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASCON_BDI_CHECK_EN
  logic bad_word;
  assign bad_word = (s_bytes > 3'd4) || (padded && !s_last && (s_bytes != 3'd4));

  // Sticky protocol error on any accepted malformed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && bad_word) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_bdi_pad.sv
// Scoreboard bench for ascon_bdi_pad: directed cases then random traffic,
// checked against a byte-level padding model.
module tb_ascon_bdi_pad;
  import ascon_bdi_pad_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic        eot;
    logic        eoi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [2:0]  s_bytes;
  logic [3:0]  s_type;
  logic        s_last, s_eoi, s_valid, s_ready;
  logic [31:0] bdi;
  logic [3:0]  bdi_type;
  logic        bdi_eot, bdi_eoi, bdi_valid;
  logic        bdi_ready = 1'b0;
  logic        err;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 0;
  logic        err_exp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [38:0] prev_word;

  ascon_bdi_pad #(.CCW(32)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_bytes(s_bytes), .s_type(s_type),
    .s_last(s_last), .s_eoi(s_eoi), .s_valid(s_valid), .s_ready(s_ready),
    .bdi(bdi), .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model: what the core must see for one accepted host word.
  function automatic void model_push(input logic [31:0] d, input logic [2:0] n,
                                     input logic [3:0] t, input logic l, input logic e);
    exp_t        x;
    int          k;
    logic [31:0] w;
    if (t != D_AD && t != D_PTCT) begin
      x = '{d, t, l, e}; exp_q.push_back(x);
    end else if (!l) begin
      x = '{d, t, 1'b0, 1'b0}; exp_q.push_back(x);
    end else begin
      k = (n > 3'd4) ? 4 : int'(n);
      if (k == 4) begin
        x = '{d, t, 1'b0, 1'b0}; exp_q.push_back(x);
        x = '{32'h80000000, t, 1'b1, e}; exp_q.push_back(x);
      end else begin
        w = 32'h0;
        for (int i = 0; i < k; i++) w[31-8*i -: 8] = d[31-8*i -: 8];
        w[31-8*k -: 8] = 8'h80;
        x = '{w, t, 1'b1, e}; exp_q.push_back(x);
      end
    end
  endfunction

  // Core-side ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bdi_ready = 1'b1;
      1:       bdi_ready = ~bdi_ready;
      2:       bdi_ready = 1'($urandom_range(0, 1));
      default: bdi_ready = 1'b0;
    endcase
  end

  // Monitor: stall stability, scoreboard pops and the error flag.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({bdi, bdi_type, bdi_eot, bdi_eoi, bdi_valid}), 64'(prev_word));
      if (bdi_valid && bdi_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({bdi, bdi_type, bdi_eot, bdi_eoi}), 64'(0));
          if ({bdi, bdi_type, bdi_eot, bdi_eoi} == 38'h0) begin
            errors++;
            $display("FAIL unexpected_output: got word with empty queue expected none");
          end
        end else begin
          e = exp_q.pop_front();
          check("bdi_word", 64'({bdi, bdi_type, bdi_eot, bdi_eoi}), 64'(e));
        end
      end
      prev_stall = bdi_valid && !bdi_ready;
      prev_word  = {bdi, bdi_type, bdi_eot, bdi_eoi, bdi_valid};
      check("err_flag", 64'(err), 64'(err_exp));
    end
  end

  // Present one host word and hold it until accepted; starts/ends at posedge+1.
  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic [3:0] t,
                      input logic l, input logic e);
    int   guard = 0;
    logic bad;
    s_data = d; s_bytes = n; s_type = t; s_last = l; s_eoi = e; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bad = 1'b0;
    if (!s_ready) begin
      check("send_timeout", 64'(0), 64'(1));
    end else begin
      model_push(d, n, t, l, e);
      bad = (n > 3'd4) || ((t == D_AD || t == D_PTCT) && !l && n != 3'd4);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
`ifdef ASCON_BDI_CHECK_EN
    if (bad) err_exp = 1'b1;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    ready_mode = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bdi_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] types [4];
    logic       l;
    types[0] = D_AD; types[1] = D_PTCT; types[2] = D_NONCE; types[3] = D_TAG;
    rst = 1'b1; s_data = 32'h0; s_bytes = 3'd0; s_type = 4'h0;
    s_last = 1'b0; s_eoi = 1'b0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bdi_valid), 64'(0));
    check("rst_word", 64'({bdi, bdi_type, bdi_eot, bdi_eoi}), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Partial last AD word and empty PTCT segment.
    ready_mode = 0;
    send(32'hAABBCC55, 3'd3, D_AD, 1'b1, 1'b0);
    send(32'h12345678, 3'd0, D_PTCT, 1'b1, 1'b1);

    // Full last AD word: pad word follows, s_ready low for exactly one cycle.
    send(32'h01020304, 3'd4, D_AD, 1'b1, 1'b1);
    @(negedge clk);
    check("pad_s_ready_low", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("pad_s_ready_back", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    drain();

    // Nonce words against a toggling core ready.
    ready_mode = 1;
    for (int i = 0; i < 4; i++) send(32'hC0DE0000 + 32'(i), 3'd4, D_NONCE, i == 3, 1'b0);
    drain();

    // Malformed AD word: err only in the checking build.
    send(32'hDEADBEEF, 3'd2, D_AD, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
`ifdef ASCON_BDI_CHECK_EN
    check("err_set_sticky", 64'(err), 64'(1));
`else
    check("err_tied_low", 64'(err), 64'(0));
`endif
    @(posedge clk); #1;
    drain();

    // Reset while in PAD with a stalled word: pad word must never appear.
    ready_mode = 3;
    idle(1);
    send(32'hCAFEF00D, 3'd4, D_PTCT, 1'b1, 1'b1);
    @(negedge clk);
    check("pad_stall_valid", 64'(bdi_valid), 64'(1));
    check("pad_stall_s_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_pad_valid", 64'(bdi_valid), 64'(0));
    check("rst_pad_s_ready", 64'(s_ready), 64'(1));
    check("rst_pad_err", 64'(err), 64'(0));
    @(posedge clk); #1;
    ready_mode = 0;
    idle(6);

    // Random traffic with random core backpressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      l = ($urandom_range(0, 2) == 0);
      send($urandom, 3'($urandom_range(0, 4)), types[$urandom_range(0, 3)],
           l, l && ($urandom_range(0, 1) == 1));
    end
    drain();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
